// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - serial ALU command deserializer with frame, CRC4 and opcode checks
module alu_serial_rx #(
  parameter int GAP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic [2:0]  cmd_op,
  output logic        err_valid,
  output logic [2:0]  err_flags,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_DATA, S_STOP} state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_TIMEOUT - 1);

  state_t      state, state_nx;
  logic        type_bit;
  logic [2:0]  bit_cnt;
  logic [7:0]  payload;
  logic [63:0] frame_buf;
  logic [3:0]  frame_cnt;
  logic        frame_err;
  logic        armed;
  logic [15:0] gap_cnt;

  logic [2:0]  rx_op;
  logic [3:0]  rx_crc;
  logic        bad_data, bad_crc, bad_op, cmd_ok, gap_hit;
  logic [2:0]  flags_nx;

  function automatic logic [3:0] crc4_d68(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // Ctl decision is evaluated while the ctl stop bit is on sin.
  assign rx_op    = payload[6:4];
  assign rx_crc   = payload[3:0];
  assign bad_data = (frame_cnt != 4'd8) || frame_err || !sin;
  assign bad_crc  = rx_crc != crc4_d68({frame_buf, 1'b1, rx_op});
  assign bad_op   = rx_op[1];
  assign cmd_ok   = !(bad_data || bad_crc || bad_op);
  assign flags_nx = bad_data ? 3'b100 : (bad_crc ? 3'b010 : 3'b001);
  assign gap_hit  = (GAP_TIMEOUT > 0) && (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (armed && !sin) state_nx = S_TYPE;
      S_TYPE:  state_nx = S_DATA;
      S_DATA:  if (bit_cnt == 3'd7) state_nx = S_STOP;
      S_STOP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_bit  <= 1'b0;
      bit_cnt   <= '0;
      payload   <= '0;
      frame_buf <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      cmd_a     <= '0;
      cmd_b     <= '0;
      cmd_op    <= '0;
      err_flags <= '0;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      gap_cnt   <= '0;
      case (state)
        S_IDLE: begin
          // Only a falling level after a seen high may start a frame.
          if (sin) armed <= 1'b1;
          if (armed && !sin) busy <= 1'b1;
          if (busy && sin) begin
            if (gap_hit) begin
              frame_buf <= '0;
              frame_cnt <= '0;
              frame_err <= 1'b0;
              busy      <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
        end
        S_TYPE: begin
          type_bit <= sin;
          bit_cnt  <= '0;
        end
        S_DATA: begin
          payload <= {payload[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
        end
        S_STOP: begin
          armed <= sin;
          if (!type_bit) begin
            frame_buf <= {frame_buf[55:0], payload};
            if (frame_cnt != 4'd9) frame_cnt <= frame_cnt + 4'd1;
            if (!sin) frame_err <= 1'b1;
          end else begin
            cmd_valid <= cmd_ok;
            err_valid <= !cmd_ok;
            if (cmd_ok) begin
              cmd_a  <= frame_buf[31:0];
              cmd_b  <= frame_buf[63:32];
              cmd_op <= rx_op;
            end else begin
              err_flags <= flags_nx;
            end
            frame_buf <= '0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - randomized self-checking bench for alu_serial_rx
module tb_alu_serial_rx;

  localparam int GAP = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        cmd_valid, err_valid, busy;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  cmd_op, err_flags;

  alu_serial_rx #(.GAP_TIMEOUT(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .cmd_valid(cmd_valid), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .err_valid(err_valid), .err_flags(err_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic        is_err;
    logic [2:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0, m_flags = '0;

  always @(negedge clk) begin
    if (cmd_valid || err_valid) begin
      checks++;
      if ((cmd_valid && err_valid) || busy !== 1'b0) begin
        errors++;
        $display("FAIL strobe_state: cmd_valid=%b err_valid=%b busy=%b, want one strobe and busy=0",
                 cmd_valid, err_valid, busy);
      end
      ev_q.push_back('{cyc: cyc, is_err: err_valid, flags: err_flags, a: cmd_a, b: cmd_b, op: cmd_op});
    end
  end

  // Remainder of m(x)*x^4 divided by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic model_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [3:0] crc, input int ndata, input int sc);
    logic [2:0] f;
    if (ndata != 8)                                    f = 3'b100;
    else if (crc != crc_ref({b, a, 1'b1, op}))         f = 3'b010;
    else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) f = 3'b001;
    else                                               f = 3'b000;
    if (f == 3'b000) begin
      m_a = a; m_b = b; m_op = op;
    end else begin
      m_flags = f;
    end
    exp_q.push_back('{cyc: sc, is_err: (f != 3'b000), flags: m_flags, a: m_a, b: m_b, op: m_op});
  endtask

  task automatic send_bit(input logic v);
    sin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pl, input int gap);
    repeat (gap) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(1'b1);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] crc, input int ndata, input int gmax, output int sc);
    logic [63:0] ba;
    logic [7:0]  by;
    ba = {b, a};
    for (int i = 0; i < ndata; i++) begin
      by = (i < 8) ? ba[63-8*i -: 8] : 8'($urandom);
      send_frame(1'b0, by, $urandom_range(gmax, 0));
    end
    send_frame(1'b1, {1'b0, op, crc}, $urandom_range(gmax, 0));
    sc = cyc;
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [3:0] crc, input int ndata, input int gmax);
    int sc;
    send_cmd(a, b, op, crc, ndata, gmax, sc);
    model_cmd(a, b, op, crc, ndata, sc);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({cmd_valid, err_valid, busy, cmd_a, cmd_b, cmd_op, err_flags} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%b busy=%b a=%h b=%h op=%b f=%b, want all 0",
               cmd_valid, err_valid, busy, cmd_a, cmd_b, cmd_op, err_flags);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) send_bit(1'b1);
  endtask

  task automatic test_good;
    logic [31:0] a, b;
    logic [2:0]  op;
    ev_t e, x;
    run_cmd(32'd1, 32'd2, 3'b100, crc_ref({32'd2, 32'd1, 1'b1, 3'b100}), 8, 0);
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      op = {$urandom_range(1, 0) == 1, 1'b0, $urandom_range(1, 0) == 1};
      run_cmd(a, b, op, crc_ref({b, a, 1'b1, op}), 8, 3);
    end
    repeat (2) send_bit(1'b1);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL good_count: got %0d strobes, want %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front(); x = exp_q.pop_front(); checks++;
      if (e !== x) begin errors++; $display("FAIL good_event: got %h, want %h", e, x); end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_errors;
    ev_t e, x;
    run_cmd(32'd1, 32'd2, 3'b100, crc_ref({32'd2, 32'd1, 1'b1, 3'b100}) + 4'd1, 8, 2);
    run_cmd(32'h1234_5678, 32'h9abc_def0, 3'b001, crc_ref({32'h9abc_def0, 32'h1234_5678, 1'b1, 3'b001}), 7, 2);
    run_cmd(32'h1234_5678, 32'h9abc_def0, 3'b001, crc_ref({32'h9abc_def0, 32'h1234_5678, 1'b1, 3'b001}), 9, 2);
    run_cmd(32'h0f0f_0f0f, 32'h00ff_00ff, 3'b111, crc_ref({32'h00ff_00ff, 32'h0f0f_0f0f, 1'b1, 3'b111}), 8, 2);
    repeat (2) send_bit(1'b1);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL err_count: got %0d strobes, want %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front(); x = exp_q.pop_front(); checks++;
      if (e !== x) begin errors++; $display("FAIL err_event: got %h, want %h", e, x); end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe;
    ev_t e, x;
    send_frame(1'b0, 8'h00, 0);
    send_frame(1'b0, 8'h00, 0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b, want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_valid, err_valid, busy, cmd_a, cmd_b, cmd_op, err_flags} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got v=%b e=%b busy=%b a=%h b=%h op=%b f=%b, want all 0",
               cmd_valid, err_valid, busy, cmd_a, cmd_b, cmd_op, err_flags);
    end
    m_a = '0; m_b = '0; m_op = '0; m_flags = '0;
    repeat (2) send_bit(1'b0);
    rst_n = 1'b1;
    repeat (3) send_bit(1'b0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_low: busy got %b, want 0", busy); end
    repeat (2) send_bit(1'b1);
    run_cmd(32'hFFFF_FFFF, 32'h0, 3'b101, crc_ref({32'h0, 32'hFFFF_FFFF, 1'b1, 3'b101}), 8, 1);
    repeat (2) send_bit(1'b1);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midframe_count: got %0d strobes, want %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front(); x = exp_q.pop_front(); checks++;
      if (e !== x) begin errors++; $display("FAIL midframe_event: got %h, want %h", e, x); end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, x;
    run_cmd(32'h5555_aaaa, 32'h0bad_f00d, 3'b000, crc_ref({32'h0bad_f00d, 32'h5555_aaaa, 1'b1, 3'b000}) ^ 4'h5, 7, 0);
    run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, crc_ref({32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b000}), 8, 0);
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'($urandom), 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_before: got %b, want 1", busy); end
    repeat (GAP / 2) send_bit(1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy_mid: got %b, want 1", busy); end
    repeat (GAP / 2 + 2) send_bit(1'b1);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy_after: got %b, want 0", busy); end
    run_cmd(32'h0000_0007, 32'h0000_0003, 3'b001, crc_ref({32'h3, 32'h7, 1'b1, 3'b001}), 8, 1);
    repeat (2) send_bit(1'b1);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d strobes, want %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front(); x = exp_q.pop_front(); checks++;
      if (e !== x) begin errors++; $display("FAIL b2b_event: got %h, want %h", e, x); end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [3:0]  adj;
    int          nd;
    ev_t e, x;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; op = 3'($urandom);
      adj = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'd0;
      case ($urandom_range(4, 0))
        0:       nd = 7;
        1:       nd = 9;
        default: nd = 8;
      endcase
      run_cmd(a, b, op, crc_ref({b, a, 1'b1, op}) + adj, nd, 2);
    end
    repeat (2) send_bit(1'b1);
    checks++;
    if (ev_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d strobes, want %0d", ev_q.size(), exp_q.size());
    end
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      e = ev_q.pop_front(); x = exp_q.pop_front(); checks++;
      if (e !== x) begin errors++; $display("FAIL rand_event: got %h, want %h", e, x); end
    end
    ev_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good();
    test_errors();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_serial_rx.md
Name: alu_serial_rx

Overview:
- Receive-side front end of the serial ALU: deserializes the command stream driven on sin by the ALU BFM and tester.
- Validates frame count, CRC4 and opcode.
- Presents either one parsed command (A, B, op) or one error report to the ALU core, as a single-cycle strobe.
- Sits between the sin pin and the ALU datapath; the response transmitter is a separate block.

Parameters:
- GAP_TIMEOUT, 64: idle-high cycles between frames after which a partial command is silently discarded; 0 disables.

Ports:
- clk  in  1  system clock; all sampling on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sin  in  1  serial input; idle high; one bit per clk
- cmd_valid  out  1  one-cycle strobe: valid command on cmd_a/cmd_b/cmd_op
- cmd_a  out  32  operand A
- cmd_b  out  32  operand B
- cmd_op  out  3  opcode
- err_valid  out  1  one-cycle strobe: command rejected
- err_flags  out  3  {err_data, err_crc, err_op}; exactly one bit set when err_valid=1
- busy  out  1  high from first start bit of a command until its strobe, timeout or reset

Behaviour:
- Frame format, 11 bits:
  - start 0
  - type bit: 0=data, 1=ctl
  - 8 payload bits, MSB first
  - stop 1
- Command is 8 data frames then 1 ctl frame.
  - Data frames 1-4 carry B[31:24]..B[7:0]; frames 5-8 carry A[31:24]..A[7:0].
  - Ctl payload is {1'b0, op[2:0], crc[3:0]}; payload bit 7 is ignored.
- Frame FSM:
  - IDLE: waits for sin=0, then goes to TYPE.
  - TYPE: latches type.
  - DATA: 8 cycles, 3-bit counter, shifts payload in.
  - STOP: samples stop bit, returns to IDLE.
  - A new start bit is accepted the cycle after STOP; back-to-back frames are supported.
- Stop bit sampled 0 (framing error): the current command is marked data-bad; the FSM returns to IDLE and hunts for a falling level.
- Data frame handling:
  - Payload shifts into a 64-bit {B,A} buffer.
  - A 4-bit frame counter saturates at 9.
  - Count 9 means "more than 8" and marks the command data-bad.
- Ctl frame, decision made on the STOP cycle:
  - err_data if frame count != 8 or framing error; else
  - err_crc if crc != CRC4 over {B, A, 1'b1, op}; else
  - err_op if op not in {AND=000, OR=001, ADD=100, SUB=101}; else
  - command OK.
- CRC4:
  - Polynomial x^4+x+1, init 0.
  - 68-bit message, MSB first, identical to the package function get_CRC4_d68.
  - May be computed serially during reception or combinationally at STOP.
- Outputs:
  - cmd_valid or err_valid goes high for exactly one cycle, the cycle after the ctl stop bit is sampled (latency 1).
  - The two strobes never assert together.
  - cmd_a/cmd_b/cmd_op hold their value until the next cmd_valid.
  - err_flags hold until the next err_valid.
- After any strobe: frame counter, error state and buffer clear; busy drops with the strobe.
- Gap timeout: with busy=1 and sin idle high for GAP_TIMEOUT consecutive cycles between frames:
  - counter and state clear;
  - busy drops;
  - no strobe is issued.
- rst_n low at any time, including mid-frame:
  - all state clears immediately;
  - FSM goes to IDLE;
  - cmd_valid=0, err_valid=0, busy=0, cmd_a=0, cmd_b=0, cmd_op=0, err_flags=0.
- After rst_n deasserts, a partial frame already on the line is ignored until sin is seen high, then low again.

Test Plan:
- Reset mid-frame: drop rst_n during data frame 3, release, then send a good command A=32'hFFFF_FFFF, B=0, SUB with correct CRC → outputs 0 during reset; exactly one cmd_valid with cmd_a=FFFF_FFFF, cmd_b=0, cmd_op=101.
- Good command: A=32'h0000_0001, B=32'h0000_0002, op=ADD(100), crc=get_CRC4_d68({B,A,1,op}) → one-cycle cmd_valid, one clk after the ctl stop bit; cmd_a=1, cmd_b=2, cmd_op=100; err_valid stays 0.
- Bad CRC: same frames with crc+1 → err_valid, err_flags=3'b010; no cmd_valid.
- 7 data frames then a ctl frame with valid CRC → err_valid, err_flags=3'b100. Repeat with 9 data frames → same 3'b100.
- Bad opcode: op=3'b111 with correct CRC over that op → err_flags=3'b001.
- Priority and recovery:
  - 7 frames plus bad CRC → err_flags=3'b100 only.
  - Then, back-to-back with no idle gap, a good AND command with A=B=32'hFFFF_FFFF → cmd_valid with cmd_op=000.
  - Then 4 data frames followed by GAP_TIMEOUT idle cycles → busy falls, no strobe.
